// File: rtl/obs_field.sv
`default_nettype none
// ============================================================================
// Module      : obs_field
// Description : Falling-obstacle field. Holds N_OBS obstacle slots, spawns
//               them at pseudo-random x positions from a 10-bit LFSR, moves
//               them down once per frame, counts obstacles that fall off the
//               bottom of the screen and renders them into the pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module obs_field #(
    parameter int         N_OBS     = 4,
    parameter int         OBS_W     = 16,
    parameter int         OBS_H     = 16,
    parameter int         STEP      = 2,
    parameter int         SPAWN_GAP = 30,
    parameter int         MAX_X     = 640,
    parameter int         MAX_Y     = 480,
    parameter logic [2:0] COLOR     = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [10:0]      pix_x,
    input  logic [10:0]      pix_y,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic [N_OBS-1:0] hit_clear,
    output logic [2:0]       rgb,
    output logic             obs_on,
    output logic [N_OBS-1:0] active,
    output logic             escaped,
    output logic [7:0]       escape_cnt
);

    localparam int               CNT_W     = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_GAP - 1);
    localparam logic [11:0]      X_RANGE   = 12'(MAX_X - OBS_W);
    localparam logic [11:0]      Y_LIMIT   = 12'(MAX_Y);
    localparam logic [11:0]      STEP_12   = 12'(STEP);
    localparam logic [11:0]      OBS_W_M1  = 12'(OBS_W - 1);
    localparam logic [11:0]      OBS_H_M1  = 12'(OBS_H - 1);
    localparam logic [9:0]       LFSR_SEED = 10'h155;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]             lfsr_q, lfsr_d;
    logic [CNT_W-1:0]       spawn_cnt_q, spawn_cnt_d;
    logic [N_OBS-1:0]       active_q, active_d;
    logic [N_OBS-1:0][10:0] x_q, x_d;
    logic [N_OBS-1:0][10:0] y_q, y_d;
    logic                   escaped_q, escaped_d;
    logic [7:0]             escape_cnt_q, escape_cnt_d;
    logic                   obs_on_q, obs_on_d;
    logic [2:0]             rgb_q, rgb_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   tick_en;
    logic                   spawn_attempt;
    logic [11:0]            lfsr_ext;
    logic [11:0]            spawn_x;
    logic [N_OBS-1:0]       free_vec;
    logic [N_OBS-1:0]       spawn_sel;
    logic                   spawn_found;
    logic [N_OBS-1:0][11:0] y_sum;
    logic [N_OBS-1:0]       hit_vec;
    logic [N_OBS-1:0]       esc_vec;
    logic [3:0]             esc_num;
    logic [8:0]             esc_total;

    assign tick_en       = frame_tick & enable;
    assign spawn_attempt = tick_en && (spawn_cnt_q == CNT_LAST);

    // Fibonacci LFSR x^10 + x^7 + 1; maximal length, so a non-zero seed never reaches zero
    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    // Spawn-interval counter, frozen while the game is paused
    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        if (tick_en) begin
            if (spawn_attempt) begin
                spawn_cnt_d = '0;
            end else begin
                spawn_cnt_d = spawn_cnt_q + 1'b1;
            end
        end
    end

    // Fold the LFSR value into the legal x range and pick the lowest free slot
    always_comb begin
        lfsr_ext    = {2'b00, lfsr_q};
        spawn_x     = (lfsr_ext < X_RANGE) ? lfsr_ext : (lfsr_ext - X_RANGE);
        // A slot being killed this cycle is not offered as a spawn target
        free_vec    = ~active_q & ~hit_clear;
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (!spawn_found && free_vec[i]) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    // Per-slot next-row sum and pixel hit test, all in 12 bits to avoid wrap
    always_comb begin
        y_sum   = '0;
        hit_vec = '0;
        for (int i = 0; i < N_OBS; i++) begin
            y_sum[i]   = {1'b0, y_q[i]} + STEP_12;
            hit_vec[i] = active_q[i]
                      && ({1'b0, pix_x} >= {1'b0, x_q[i]})
                      && ({1'b0, pix_x} <= ({1'b0, x_q[i]} + OBS_W_M1))
                      && ({1'b0, pix_y} >= {1'b0, y_q[i]})
                      && ({1'b0, pix_y} <= ({1'b0, y_q[i]} + OBS_H_M1));
        end
    end

    // Slot update: kill request wins, then spawn into a free slot, then frame motion
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        esc_vec  = '0;
        for (int i = 0; i < N_OBS; i++) begin
            if (hit_clear[i]) begin
                active_d[i] = 1'b0;
            end else if (spawn_attempt && spawn_sel[i]) begin
                active_d[i] = 1'b1;
                x_d[i]      = spawn_x[10:0];
                y_d[i]      = '0;
            end else if (tick_en && active_q[i]) begin
                if (y_sum[i] >= Y_LIMIT) begin
                    active_d[i] = 1'b0;
                    esc_vec[i]  = 1'b1;
                end else begin
                    y_d[i] = y_sum[i][10:0];
                end
            end
        end
    end

    // Escape pulse and saturating escape counter
    always_comb begin
        esc_num = '0;
        for (int i = 0; i < N_OBS; i++) begin
            esc_num = esc_num + {3'b000, esc_vec[i]};
        end
        esc_total    = {1'b0, escape_cnt_q} + {5'b00000, esc_num};
        escape_cnt_d = esc_total[8] ? 8'hFF : esc_total[7:0];
        escaped_d    = |esc_vec;
    end

    // Pixel output stage; overlapping obstacles simply OR together
    always_comb begin
        obs_on_d = video_on & (|hit_vec);
        rgb_d    = obs_on_d ? COLOR : 3'b000;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q       <= LFSR_SEED;
            spawn_cnt_q  <= '0;
            active_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            escaped_q    <= 1'b0;
            escape_cnt_q <= '0;
            obs_on_q     <= 1'b0;
            rgb_q        <= 3'b000;
        end else begin
            lfsr_q       <= lfsr_d;
            spawn_cnt_q  <= spawn_cnt_d;
            active_q     <= active_d;
            x_q          <= x_d;
            y_q          <= y_d;
            escaped_q    <= escaped_d;
            escape_cnt_q <= escape_cnt_d;
            obs_on_q     <= obs_on_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign obs_on     = obs_on_q;
    assign active     = active_q;
    assign escaped    = escaped_q;
    assign escape_cnt = escape_cnt_q;

endmodule
`default_nettype wire

// File: doc/obs_field.md
OBS_FIELD -- requirements
Module: obs_field

Interface
REQ-001 The block SHALL have parameter N_OBS, default 4, number of obstacle slots (1..8).
REQ-002 The block SHALL have parameter OBS_W, default 16, obstacle width in pixels.
REQ-003 The block SHALL have parameter OBS_H, default 16, obstacle height in pixels.
REQ-004 The block SHALL have parameter STEP, default 2, downward pixels moved per frame.
REQ-005 The block SHALL have parameter SPAWN_GAP, default 30, frames between spawn attempts.
REQ-006 The block SHALL have parameters MAX_X default 640, MAX_Y default 480 (screen size), and COLOR default 3'b111.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-009 The block SHALL have port video_on, input, 1 bit: visible-area flag.
REQ-010 The block SHALL have ports pix_x and pix_y, input, 11 bits each: current scan pixel.
REQ-011 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per frame.
REQ-012 The block SHALL have port enable, input, 1 bit: game running; 0 freezes motion, spawning and escape counting.
REQ-013 The block SHALL have port hit_clear, input, N_OBS bits: per-slot kill request from collision logic.
REQ-014 The block SHALL have port rgb, output, 3 bits: pixel colour.
REQ-015 The block SHALL have port obs_on, output, 1 bit: current pixel lies inside an active obstacle.
REQ-016 The block SHALL have port active, output, N_OBS bits: slot-occupied flags.
REQ-017 The block SHALL have port escaped, output, 1 bit: one-cycle pulse when at least one obstacle leaves the screen.
REQ-018 The block SHALL have port escape_cnt, output, 8 bits: saturating count of escaped obstacles.

Function
REQ-019 Each slot SHALL hold an active bit, x[10:0] and y[10:0] (top-left corner).
REQ-020 A 10-bit Fibonacci LFSR (x^10+x^7+1) SHALL advance every clock, seed 10'h155, and never reach all-zero.
REQ-021 A spawn counter SHALL increment on each frame_tick with enable=1; on a tick where it equals SPAWN_GAP-1 it SHALL return to 0 and perform a spawn attempt.
REQ-022 A spawn SHALL fill the lowest-index slot whose active bit is 0 at the start of the cycle, setting y=0, active=1, and x = L if L < MAX_X-OBS_W, else L-(MAX_X-OBS_W), where L is the current LFSR value.
REQ-023 If no slot is free, the spawn SHALL be dropped, and the counter SHALL still return to 0.
REQ-024 On frame_tick with enable=1, every active slot not spawned in that cycle SHALL compute y+STEP in 12 bits; if the sum is >= MAX_Y, the slot SHALL become inactive, else y SHALL take the sum.
REQ-025 escaped SHALL pulse high for exactly the cycle after a tick in which one or more slots deactivated by REQ-024.
REQ-026 escape_cnt SHALL add the number of slots that escaped on that tick and saturate at 255.
REQ-027 hit_clear[i]=1 SHALL deactivate slot i in that cycle regardless of enable, SHALL take priority over movement, and SHALL NOT count as an escape.
REQ-028 A slot cleared in a cycle SHALL NOT be a spawn target in that same cycle.
REQ-029 With enable=0, frame_tick SHALL have no effect; hit_clear SHALL still act.
REQ-030 Hit test: slot i SHALL match when active, x<=pix_x<=x+OBS_W-1 and y<=pix_y<=y+OBS_H-1, computed in 12 bits.
REQ-031 obs_on and rgb SHALL be registered with 1-cycle latency from pix_x/pix_y/video_on: obs_on = video_on AND (OR of matches); rgb = COLOR when obs_on, else 3'b000.
REQ-032 Overlapping obstacles SHALL render identically to a single obstacle.
REQ-033 The active output SHALL be the registered slot-occupied vector, with no extra latency beyond its register.

Reset
REQ-034 While reset=0 at a clock edge, all slots SHALL become inactive (x=y=0), the spawn counter SHALL be 0, the LFSR SHALL be 10'h155, and rgb=0, obs_on=0, active=0, escaped=0, escape_cnt=0.
REQ-035 Reset asserted mid-frame SHALL discard all obstacles, with no escape pulse and no count change.

Verification
REQ-036 Reset, then 29 ticks with enable=1 -> active=0. On the 30th tick -> active=4'b0001, slot0 y=0, x<624.
REQ-037 Slot0 spawned at y=0 with 240 further ticks -> y=478 after tick 239. On tick 240 -> active[0]=0, escaped pulses 1 cycle, escape_cnt=1.
REQ-038 All 4 slots active and a 5th spawn tick -> spawn dropped, active=4'b1111, counter back to 0.
REQ-039 hit_clear=4'b0010 on the same cycle as a frame_tick -> slot1 inactive, no escape, and the next spawn fills slot1.
REQ-040 Slot at x=100, y=50, video_on=1; scan pix (100,50), (115,65) and (116,65) -> obs_on=1, 1, 0 one cycle later, with rgb=3'b111, 3'b111, 3'b000. video_on=0 at (100,50) -> obs_on=0.
REQ-041 enable=0 for 10 ticks -> positions, spawn counter and escape_cnt unchanged.
